// File: rtl/lza_norm_arb.sv
// Round-robin arbiter sharing one leading-zero anticipator among NREQ requesters, two-stage pipeline.
// Optional accept/zero statistics counters are enabled with `define LZA_NORM_ARB_STATS_EN.
module lza_norm_arb #(
    parameter int WIDTH     = 107,
    parameter int NREQ      = 4,
    parameter int MAX_SHIFT = 106
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_op_a,
    input  logic [NREQ*WIDTH-1:0]  req_op_b,
    output logic [WIDTH-1:0]       lza_in_01,
    output logic [WIDTH-1:0]       lza_in_02,
    input  logic [6:0]             lza_zero_cnt,
    input  logic                   lza_invalid,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_id,
    output logic [6:0]             rsp_shift,
    output logic                   rsp_zero,
    output logic                   busy
`ifdef LZA_NORM_ARB_STATS_EN
    ,
    output logic [15:0]            stat_req,
    output logic [15:0]            stat_zero
`endif
);

    localparam int         IDW       = 2;
    localparam logic [6:0] SHIFT_CAP = 7'(MAX_SHIFT);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [IDW-1:0]   s1_id_q, s1_id_d;
    logic             s2_valid_q, s2_valid_d;
    logic [IDW-1:0]   s2_id_q, s2_id_d;
    logic [6:0]       s2_shift_q, s2_shift_d;
    logic             s2_zero_q, s2_zero_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   scan_idx;
    logic             s2_can_load, s1_move, s1_can_load, accept;
    logic [6:0]       shift_sat;

`ifdef LZA_NORM_ARB_STATS_EN
    logic [15:0]      stat_req_q, stat_req_d;
    logic [15:0]      stat_zero_q, stat_zero_d;
`endif

    // Search upward from the pointer; the 2-bit index wraps modulo NREQ on its own.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ptr_q + IDW'(k);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx;
            end
        end
    end

    always_comb begin
        s2_can_load = !s2_valid_q || rsp_ready;
        s1_move     = s1_valid_q && s2_can_load;
        s1_can_load = !s1_valid_q || s1_move;
        // rst_n gates the grant so req_ready reads zero throughout reset.
        accept      = gnt_found && s1_can_load && !flush && rst_n;

        req_ready = '0;
        if (accept) req_ready[gnt_id] = 1'b1;

        if (lza_invalid)                  shift_sat = 7'd0;
        else if (lza_zero_cnt > SHIFT_CAP) shift_sat = SHIFT_CAP;
        else                              shift_sat = lza_zero_cnt;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_shift_d = s2_shift_q;
        s2_zero_d  = s2_zero_q;
        ptr_d      = ptr_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_move) begin
                s2_valid_d = 1'b1;
                s2_id_d    = s1_id_q;
                s2_shift_d = shift_sat;
                s2_zero_d  = lza_invalid;
            end else if (rsp_ready) begin
                s2_valid_d = 1'b0;
            end

            if (accept) begin
                s1_valid_d = 1'b1;
                s1_a_d     = req_op_a[gnt_id*WIDTH +: WIDTH];
                s1_b_d     = req_op_b[gnt_id*WIDTH +: WIDTH];
                s1_id_d    = gnt_id;
                ptr_d      = gnt_id + IDW'(1);
            end else if (s1_move) begin
                s1_valid_d = 1'b0;
            end
        end
    end

`ifdef LZA_NORM_ARB_STATS_EN
    always_comb begin
        stat_req_d  = stat_req_q;
        stat_zero_d = stat_zero_q;
        if (flush) begin
            stat_req_d  = '0;
            stat_zero_d = '0;
        end else begin
            if (accept && stat_req_q != 16'hFFFF)
                stat_req_d = stat_req_q + 16'd1;
            if (s1_move && lza_invalid && stat_zero_q != 16'hFFFF)
                stat_zero_d = stat_zero_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_req_q  <= '0;
            stat_zero_q <= '0;
        end else begin
            stat_req_q  <= stat_req_d;
            stat_zero_q <= stat_zero_d;
        end
    end

    assign stat_req  = stat_req_q;
    assign stat_zero = stat_zero_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            // NOTE: the operand registers are reset as well so the anticipator inputs read zero after reset.
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_shift_q <= '0;
            s2_zero_q  <= 1'b0;
            ptr_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_shift_q <= s2_shift_d;
            s2_zero_q  <= s2_zero_d;
            ptr_q      <= ptr_d;
        end
    end

    assign lza_in_01 = s1_valid_q ? s1_a_q : '0;
    assign lza_in_02 = s1_valid_q ? s1_b_q : '0;
    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_shift = s2_shift_q;
    assign rsp_zero  = s2_zero_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: doc/lza_norm_arb.md
LZA_NORM_ARB -- requirements
Module: lza_norm_arb

Interface
REQ-001 Parameter WIDTH, default 107: operand width of the shared leading-zero anticipator.
REQ-002 Parameter NREQ, default 4: number of requesters; fixed at 4 (2-bit id).
REQ-003 Parameter MAX_SHIFT, default 106: saturation bound for the reported shift.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous pipeline clear.
REQ-007 req_valid  input  NREQ  per-requester request valid.
REQ-008 req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-009 req_op_a  input  NREQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
REQ-010 req_op_b  input  NREQ*WIDTH  operand B, same packing.
REQ-011 lza_in_01  output  WIDTH  operand A to the shared anticipator.
REQ-012 lza_in_02  output  WIDTH  operand B to the shared anticipator.
REQ-013 lza_zero_cnt  input  7  combinational count returned by the anticipator.
REQ-014 lza_invalid  input  1  anticipator all-zero flag.
REQ-015 rsp_valid  output  1  response valid.
REQ-016 rsp_ready  input  1  response consumer ready.
REQ-017 rsp_id  output  2  index of the requester served.
REQ-018 rsp_shift  output  7  normalization shift.
REQ-019 rsp_zero  output  1  result is all-zero.
REQ-020 busy  output  1  high when stage S1 or stage S2 is occupied.

Function
REQ-021 Pipeline: S1 (operand register plus valid) and S2 (response register plus valid).
- Transfer on valid&ready at every boundary.
REQ-022 Arbitration: round-robin pointer.
- Grant the lowest index i, searched from the pointer upward mod NREQ, with req_valid[i]=1.
REQ-023 req_ready[grant]=1 only when S1 is empty or draining into S2 this cycle, and flush=0.
- All other req_ready bits are 0.
REQ-024 On accept of requester i: load S1 with ops and id i; pointer becomes (i+1) mod NREQ.
- Pointer is unchanged on cycles without an accept.
REQ-025 lza_in_01/lza_in_02 are driven from the S1 registers; they are all-zero while S1 is empty.
REQ-026 S1 moves to S2 when S2 is empty or rsp_ready=1.
- S2 captures id, lza_invalid, and the shift.
- Shift = 0 if lza_invalid, else min(lza_zero_cnt, MAX_SHIFT).
REQ-027 rsp_zero equals the captured lza_invalid.
REQ-028 Latency: accept in cycle N gives rsp_valid in cycle N+2 when there is no backpressure.
REQ-029 Throughput: one accept per cycle when rsp_ready is held at 1.
REQ-030 Backpressure: while rsp_valid=1 and rsp_ready=0, S2 holds all response outputs stable.
- S1 holds when S2 is full and not draining; req_ready is then all-zero.
REQ-031 flush=1: both valids clear next edge; pointer is kept; no accept that cycle; flush overrides simultaneous request and response handshakes.
REQ-032 A requester that drops req_valid before its grant is never served.
- Data captured on an accept is never lost or duplicated.

Reset
REQ-033 rst_n low asynchronously clears: S1/S2 valids, pointer to 0, rsp_id/rsp_shift/rsp_zero to 0, req_ready to 0, busy to 0, lza_in_01/lza_in_02 to 0.
REQ-034 Reset asserted mid-operation discards in-flight entries; the first accept after release grants the lowest valid index from pointer 0.

Configuration
REQ-035 Macro LZA_NORM_ARB_STATS_EN adds ports stat_req (16-bit output, count of accepts) and stat_zero (16-bit output, count of S2 captures with lza_invalid=1).
- Both counters saturate at 16'hFFFF.
- Reset and flush clear both counters.
REQ-036 Without the macro, neither the ports nor the counters exist; all other behaviour is identical.

Verification
REQ-037 Single request: req0 with A=B=0 -> rsp_valid at N+2, rsp_id=0, rsp_zero=1, rsp_shift=0.
REQ-038 All four requesters continuously valid, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence matches two cycles later.
REQ-039 Backpressure: rsp_ready=0 for 5 cycles with 3 requests pending -> S2 outputs stable, req_ready=0 after S1 fills, no loss or duplication after release.
REQ-040 Saturation: model lza_zero_cnt=120 with lza_invalid=0 -> rsp_shift=106, rsp_zero=0.
REQ-041 flush asserted alongside req_valid=4'b1111 with both stages full -> no accept, busy=0 next cycle, pointer unchanged.
REQ-042 rst_n pulsed low while both stages are full -> outputs zero immediately; with STATS_EN, 70000 accepts -> stat_req=16'hFFFF.
